skein_target_check: RTL

- Sits directly downstream of the skein512 hash pipeline.
- Each cycle it samples the 512-bit digest and the free-running nonce counter. When the upstream valid strobe is high, it reconstructs the nonce that produced the digest and compares the digest's leading 64-bit word against a target.
- Winning ("golden") nonces are queued in a small FIFO and drained by the host/UART side through a valid/ready handshake.
- Also keeps hash and overflow statistics.

---
 rtl/skein_pkg.sv | 21 ++
 rtl/sync_fifo_sa.sv | 86 ++++++++
 rtl/skein_target_check.sv | 110 +++++++++++
 3 files changed

// File: rtl/skein_pkg.sv
// Shared types and helpers for the skein512 result-checking logic.
// The digest word is reversed byte-wise before it is compared against the target.
package skein_pkg;

  localparam logic [31:0] SKEIN_LATENCY = 32'd110;

  typedef struct packed {
    logic [31:0] nonce;
    logic [63:0] word;
  } result_t;

  function automatic logic [63:0] bswap64(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y[8*i +: 8] = x[8*(7-i) +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Generic show-ahead FIFO. The head is always visible on dout. When the FIFO
// is empty, dout keeps showing the most recently popped entry.
module sync_fifo_sa #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));

  // When full, a push is only accepted if the head leaves on the same edge.
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        last_d   = mem_q[rd_ptr_q];
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end

  // NOTE: storage has no reset; it is only read behind a non-zero level, so
  // contents left over from before a reset are never observable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = empty ? last_q : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/skein_target_check.sv
// Compares skein512 digests against a target, queues golden nonces for the
// host and keeps hash and overflow statistics.
module skein_target_check
  import skein_pkg::*;
#(
  parameter logic [31:0] NONCE_OFFSET = SKEIN_LATENCY,
  parameter int          DEPTH        = 4,
  parameter int          CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [511:0]           hash,
  input  logic                   hash_valid,
  input  logic [31:0]            nonce_in,
  input  logic [63:0]            target,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_nonce,
  output logic [63:0]            res_word,
  output logic [31:0]            hash_count,
  output logic [CNT_W-1:0]       ovf_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  logic        s1_v_q, s1_v_d;
  logic [31:0] s1_nonce_q, s1_nonce_d;
  logic [63:0] s1_word_q, s1_word_d;
  logic        s2_gold_q, s2_gold_d;
  result_t     s2_res_q, s2_res_d;
  logic [31:0]      hash_count_q, hash_count_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  logic    fifo_full, fifo_empty, pop;
  result_t head;
  logic    unused_hash;

  // Only the leading digest word takes part in the comparison.
  assign unused_hash = ^hash[511:64];

  assign pop = ~fifo_empty & res_ready;

  // NOTE: every value assigned in this block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    s1_v_d       = hash_valid & ~clear;
    s1_nonce_d   = nonce_in - NONCE_OFFSET;
    s1_word_d    = bswap64(hash[63:0]);
    s2_gold_d    = s1_v_q & ~clear & (s1_word_q <= target);
    s2_res_d     = '{nonce: s1_nonce_q, word: s1_word_q};
    hash_count_d = hash_count_q;
    ovf_count_d  = ovf_count_q;
    if (clear) begin
      hash_count_d = '0;
      ovf_count_d  = '0;
    end else begin
      if (hash_valid) begin
        hash_count_d = hash_count_q + 32'd1;
      end
      if (s2_gold_q && fifo_full && !pop && ovf_count_q != '1) begin
        ovf_count_d = ovf_count_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q       <= 1'b0;
      s1_nonce_q   <= '0;
      s1_word_q    <= '0;
      s2_gold_q    <= 1'b0;
      s2_res_q     <= '0;
      hash_count_q <= '0;
      ovf_count_q  <= '0;
    end else begin
      s1_v_q       <= s1_v_d;
      s1_nonce_q   <= s1_nonce_d;
      s1_word_q    <= s1_word_d;
      s2_gold_q    <= s2_gold_d;
      s2_res_q     <= s2_res_d;
      hash_count_q <= hash_count_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  sync_fifo_sa #(
    .WIDTH ($bits(result_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .push  (s2_gold_q),
    .pop   (pop),
    .din   (s2_res_q),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign res_valid  = ~fifo_empty;
  assign res_nonce  = head.nonce;
  assign res_word   = head.word;
  assign hash_count = hash_count_q;
  assign ovf_count  = ovf_count_q;

endmodule
